// File: rtl/instr_queue_pkg.sv
// cpu_defs: shared CPU front-end types used by the instruction queue.
//   uint32_t / virt_t : 32-bit instruction word and virtual address
//   iq_entry_t        : one buffered instruction {pc, instr, is_ctrl}
//   IQ_PUSH_LANES     : instructions fetch may deliver per cycle
package cpu_defs;

  typedef logic [31:0] uint32_t;
  typedef logic [31:0] virt_t;

  localparam int IQ_PUSH_LANES = 2;

  typedef struct packed {
    virt_t   pc;
    uint32_t instr;
    logic    is_ctrl;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue_if.sv
// instr_queue_if: fetch-side push port and decode-side head/pop port.
//   slave  : the queue (consumes push/pop/flush, drives full and head_*)
//   master : the environment driving fetch and decode
// Lane 0 is always the older instruction.
interface instr_queue_if;
  logic             flush;
  logic [1:0]       push_valid;
  logic [1:0][31:0] push_instr;
  logic [1:0][31:0] push_pc;
  logic             full;
  logic [1:0]       pop_num;
  logic [1:0]       head_valid;
  logic [1:0][31:0] head_instr;
  logic [1:0][31:0] head_pc;
  logic [1:0]       head_is_ctrl;

  modport slave (
    input  flush, push_valid, push_instr, push_pc, pop_num,
    output full, head_valid, head_instr, head_pc, head_is_ctrl
  );

  modport master (
    output flush, push_valid, push_instr, push_pc, pop_num,
    input  full, head_valid, head_instr, head_pc, head_is_ctrl
  );
endinterface

// File: rtl/instr_queue_predecode.sv
// iq_predecode: combinational control-flow classifier for one push lane.
//   instr_i   : fetched instruction word
//   is_ctrl_o : 1 for REGIMM branches, J/JAL, BEQ/BNE/BLEZ/BGTZ, JR/JALR
module iq_predecode (
  input  logic [31:0] instr_i,
  output logic        is_ctrl_o
);
  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr_i[31:26];
  assign funct  = instr_i[5:0];

  always_comb begin
    is_ctrl_o = 1'b0;
    casez (opcode)
      6'b000001, 6'b00001?, 6'b0001??: is_ctrl_o = 1'b1;
      // SPECIAL: only JR (001000) and JALR (001001)
      6'b000000: is_ctrl_o = (funct[5:1] == 5'b00100);
      default:   is_ctrl_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/instr_queue.sv
// instr_queue: circular FIFO between fetch and the dual decoders.
//   clk, rst : clock, synchronous active-high reset
//   iq       : instr_queue_if.slave (push lanes, flush, pop_num, head lanes, full)
// Optional build macro IQ_DELAY_SLOT_HOLD_EN: mask head_valid so a branch or
// jump is only presented together with its delay slot.
module instr_queue
  import cpu_defs::*;
#(
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  instr_queue_if.slave   iq
);
  localparam int PW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  iq_entry_t mem_q [DEPTH];
  ptr_t      rptr_q, rptr_d, wptr_q, wptr_d;
  cnt_t      count_q, count_d;
  ptr_t      rptr_nxt, wptr_nxt;
  iq_entry_t head0, head1;
  logic [IQ_PUSH_LANES-1:0] lane_ctrl;
  logic [1:0] raw_valid, head_valid;
  logic       push_ok;
  cnt_t       n_push, n_pop, n_avail;

  for (genvar l = 0; l < IQ_PUSH_LANES; l++) begin : g_pre
    iq_predecode u_pre (
      .instr_i   (iq.push_instr[l]),
      .is_ctrl_o (lane_ctrl[l])
    );
  end

  assign rptr_nxt  = rptr_q + ptr_t'(1);
  assign wptr_nxt  = wptr_q + ptr_t'(1);
  assign head0     = mem_q[rptr_q];
  assign head1     = mem_q[rptr_nxt];
  assign raw_valid = {count_q >= cnt_t'(2), count_q != '0};

`ifdef IQ_DELAY_SLOT_HOLD_EN
  always_comb begin
    head_valid = raw_valid;
    if (raw_valid[0] && !raw_valid[1] && head0.is_ctrl)
      head_valid = 2'b00;   // branch waiting for its slot
    else if (raw_valid[1] && !head0.is_ctrl && head1.is_ctrl)
      head_valid = 2'b01;   // branch in lane 1 waits to become lane 0
  end
`else
  assign head_valid = raw_valid;
`endif

  assign iq.full         = count_q > cnt_t'(DEPTH - 2);
  assign iq.head_valid   = head_valid;
  assign iq.head_instr   = {head1.instr, head0.instr};
  assign iq.head_pc      = {head1.pc, head0.pc};
  assign iq.head_is_ctrl = {head1.is_ctrl, head0.is_ctrl};

  assign push_ok = !iq.full && !iq.flush;
  assign n_push  = push_ok ? cnt_t'(iq.push_valid[0]) + cnt_t'(iq.push_valid[1]) : '0;
  assign n_avail = cnt_t'(head_valid[0]) + cnt_t'(head_valid[1]);
  assign n_pop   = (cnt_t'(iq.pop_num) < n_avail) ? cnt_t'(iq.pop_num) : n_avail;

  always_comb begin
    rptr_d  = rptr_q + ptr_t'(n_pop);
    wptr_d  = wptr_q + ptr_t'(n_push);
    count_d = count_q + n_push - n_pop;
    if (iq.flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset; contents are only observed through count_q.
  always_ff @(posedge clk) begin
    if (push_ok && iq.push_valid[0])
      mem_q[wptr_q] <= '{pc: iq.push_pc[0], instr: iq.push_instr[0], is_ctrl: lane_ctrl[0]};
    if (push_ok && iq.push_valid[1])
      mem_q[wptr_nxt] <= '{pc: iq.push_pc[1], instr: iq.push_instr[1], is_ctrl: lane_ctrl[1]};
  end

  a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
    !(iq.full && !iq.flush && (iq.push_valid != 2'b00)))
    else $error("instr_queue: push while full");

endmodule
